// File: rtl/pin_bank_ctrl_if.sv
// Byte-stream handshake bundle between the host link and pin_bank_ctrl.
// The host drives rx_* and tx_ready. The controller drives rx_ready and tx_*.
interface pin_bank_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/pin_bank_ctrl.sv
// Pin bank controller: the host writes BANKS drive bytes, which are committed
// atomically. The host can also read a frozen snapshot of the sampled pins,
// followed by an XOR checksum byte. The host can enable or disable the pin
// drivers.
//
// state     | meaning
// IDLE      | wait for a command byte ('W', 'R', 'E', 'D')
// WR_DATA   | collect BANKS drive bytes into the shadow
// COMMIT    | copy the shadow to the outputs in one edge
// RD_SNAP   | freeze the input pins, clear the checksum and the index
// RD_SEND   | stream BANKS snapshot bytes, then the checksum byte
module pin_bank_ctrl #(
    parameter int BANKS     = 17,
    parameter int PINS_CONT = 132
) (
    input  logic            CLK50,
    input  logic            RST,
    pin_bank_ctrl_if.slave  bus,
    input  logic [7:0]      input_pins_state  [0:BANKS-1],
    output logic [7:0]      output_pins_state [0:BANKS-1],
    output logic            write_enable,
    output logic            busy,
    output logic            err
);

    localparam int IW = $clog2(BANKS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BANKS - 1);
    localparam logic [IW-1:0] CSUM_IDX = IW'(BANKS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_SNAP   = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;

    // The total pin count must fit inside the 8-bit banks.
    if (PINS_CONT > 8 * BANKS) begin : g_pins_range
        $error("pin_bank_ctrl: PINS_CONT does not fit in BANKS bytes");
    end

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    shadow_q [0:BANKS-1];
    logic [7:0]    shadow_d [0:BANKS-1];
    logic [7:0]    snap_q   [0:BANKS-1];
    logic [7:0]    snap_d   [0:BANKS-1];
    logic [7:0]    out_q    [0:BANKS-1];
    logic [7:0]    out_d    [0:BANKS-1];
    logic [7:0]    csum_q, csum_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    // Holds rx_ready low during reset and releases it at the first edge after reset.
    logic          run_q, run_d;

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = bus.rx_valid && bus.rx_ready;
    assign tx_fire = bus.tx_valid && bus.tx_ready;

    assign bus.rx_ready = run_q && ((state_q == S_IDLE) || (state_q == S_WR));
    assign bus.tx_valid = (state_q == S_SEND);
    // tx_data depends only on frozen snapshot state, so it holds while tx_ready is low.
    assign bus.tx_data  = (state_q != S_SEND) ? 8'h00 :
                          (idx_q == CSUM_IDX) ? csum_q : snap_q[idx_q];

    assign output_pins_state = out_q;
    assign write_enable      = we_q;
    assign busy              = (state_q != S_IDLE);
    assign err               = err_q;

    // Next-state logic for the command FSM and its datapath.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        out_d    = out_q;
        csum_d   = csum_q;
        we_d     = we_q;
        err_d    = 1'b0;
        run_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    case (bus.rx_data)
                        8'h57: begin
                            state_d = S_WR;
                            idx_d   = '0;
                        end
                        8'h52:   state_d = S_SNAP;
                        8'h45:   we_d    = 1'b1;
                        8'h44:   we_d    = 1'b0;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            S_WR: begin
                if (rx_fire) begin
                    shadow_d[idx_q] = bus.rx_data;
                    idx_d           = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                out_d   = shadow_q;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            S_SNAP: begin
                snap_d  = input_pins_state;
                csum_d  = 8'h00;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_fire) begin
                    if (idx_q == CSUM_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        csum_d = csum_q ^ snap_q[idx_q];
                        idx_d  = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers: asynchronous clear, synchronous release.
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < BANKS; i++) begin
                shadow_q[i] <= 8'h00;
                snap_q[i]   <= 8'h00;
                out_q[i]    <= 8'h00;
            end
            csum_q  <= 8'h00;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            out_q    <= out_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            err_q    <= err_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: doc/pin_bank_ctrl.md
PIN_BANK_CTRL -- requirements
Module: pin_bank_ctrl

Interface
REQ-001 SHALL have parameter BANKS, default 17, number of 8-bit pin-state banks.
REQ-002 SHALL have parameter PINS_CONT, default 132, total pin count carried in the banks and used for documentation and range checks only.
REQ-003 SHALL have port CLK50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  command/data byte from the host.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  block accepts rx_data; a byte transfers on a CLK50 edge with rx_valid && rx_ready.
REQ-008 SHALL have port tx_data  output  8  response byte to the host.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  host accepts tx_data; a byte transfers on a CLK50 edge with tx_valid && tx_ready.
REQ-011 SHALL have port input_pins_state  input  8 x [0:BANKS-1]  sampled pin levels from the pin I/O block.
REQ-012 SHALL have port output_pins_state  output  8 x [0:BANKS-1]  pin drive values to the pin I/O block.
REQ-013 SHALL have port write_enable  output  1  pin drive enable to the pin I/O block.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port err  output  1  one-cycle pulse on an unknown command byte.

Function
REQ-016 SHALL implement the states IDLE, WR_DATA, COMMIT, RD_SNAP and RD_SEND.
REQ-017 SHALL drive rx_ready=1 only in IDLE and WR_DATA.
REQ-018 SHALL drive tx_valid=1 only in RD_SEND.
REQ-019 In IDLE, command 0x57 ('W') accepted SHALL go to WR_DATA with index=0.
REQ-020 In IDLE, command 0x52 ('R') accepted SHALL go to RD_SNAP.
REQ-021 In IDLE, command 0x45 ('E') accepted SHALL set write_enable=1 at the next edge and stay in IDLE.
REQ-022 In IDLE, command 0x44 ('D') accepted SHALL clear write_enable=0 at the next edge and stay in IDLE.
REQ-023 In IDLE, any other accepted byte SHALL pulse err for exactly one cycle, stay in IDLE, and change no other state.
REQ-024 In WR_DATA, each accepted byte SHALL be stored to shadow[index] and index SHALL increment; the byte accepted at index=BANKS-1 SHALL move the state to COMMIT.
REQ-025 COMMIT SHALL last one cycle, copy all BANKS shadow bytes to output_pins_state atomically at the same edge, and return to IDLE; the new values SHALL be visible one cycle after the last data byte is accepted.
REQ-026 output_pins_state SHALL never show a partial update.
REQ-027 RD_SNAP SHALL last one cycle, capture all input_pins_state bytes into a snapshot and clear the checksum and index; the state SHALL then go to RD_SEND.
REQ-028 In RD_SEND, the block SHALL send snapshot[0]..snapshot[BANKS-1] in order, then one checksum byte equal to the XOR of all snapshot bytes, BANKS+1 bytes in total.
REQ-029 After the checksum byte is accepted, the state SHALL return to IDLE.
REQ-030 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable; the index SHALL advance only on a transfer.
REQ-031 Changes on input_pins_state after RD_SNAP SHALL NOT affect the bytes sent.
REQ-032 A read SHALL NOT change output_pins_state or write_enable.
REQ-033 The rx_valid level outside IDLE and WR_DATA SHALL be ignored; no byte is consumed.
REQ-034 The index width SHALL be ceil(log2(BANKS+1)) bits; no wrap-around is allowed.
REQ-035 In WR_DATA, rx_valid gaps of any length SHALL be tolerated with no timeout.
REQ-036 Minimum transaction latency SHALL be: 'W' = BANKS+2 cycles from the command to IDLE; 'R' = 1 snapshot cycle + BANKS+1 transfers.

Reset
REQ-037 While RST=1, the block SHALL force state=IDLE, index=0, the shadow, snapshot and output_pins_state all 0x00, write_enable=0, tx_valid=0, tx_data=0x00, err=0, busy=0 and rx_ready=0.
REQ-038 Reset SHALL take effect asynchronously and release synchronously to CLK50; rx_ready SHALL go to 1 on the first edge after release.
REQ-039 RST asserted mid-write SHALL discard the shadow, leaving output_pins_state=0.
REQ-040 RST asserted mid-read SHALL drop tx_valid immediately.

Verification
REQ-041 Write test: 'W' then bytes 0x01..0x11 at full rate -> output_pins_state[0]=0x01 and [16]=0x11 together one cycle after the last byte; busy=0 the following cycle.
REQ-042 Read test: input_pins_state[i]=0xA0+i, send 'R' with tx_ready=1 -> 17 bytes 0xA0..0xB0 followed by checksum 0xB0.
REQ-043 Backpressure and snapshot test: during a read, hold tx_ready=0 for 5 cycles at index 3 while changing input_pins_state -> tx_data stays 0xA3 and all later bytes match the snapshot.
REQ-044 Enable test: 'E' -> write_enable=1 on the next edge; 'D' -> write_enable=0.
REQ-045 Error test: byte 0x00 -> err high for exactly 1 cycle; output_pins_state and write_enable unchanged.
REQ-046 Reset-mid-write test: 'W', 8 data bytes, then RST pulse -> all outputs at reset values; a following full 'W' commits correctly.
